// File: rtl/inst_fetch.sv
// inst_fetch: two-state instruction fetch stage (IDLE / FETCH).
// Drives a combinational 64-bit instruction ROM with an 8-byte aligned
// address. Per-cycle priority is flush > branch > stall > sequential.
// The fetched instruction is registered into the ID outputs one cycle later.
// Optional feature: define INST_FETCH_PERF_EN to add the fetch_cnt output,
// which counts every instruction loaded into ID.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [63:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [63:0] id_inst,
    output logic        id_valid,
    output logic        misalign_err
`ifdef INST_FETCH_PERF_EN
   ,output logic [31:0] fetch_cnt
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    // The ROM is 64 bits wide, so the fetch address is always 8-byte aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd7;

    logic [0:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        rom_ce_q,   rom_ce_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [63:0] id_inst_q,  id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
`endif

    // Next-state logic: FSM plus flush > branch > stall > sequential selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        misalign_d = 1'b0;
`ifdef INST_FETCH_PERF_EN
        fetch_cnt_d = fetch_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Redirect/stall inputs are ignored until fetching starts.
                state_d    = FETCH;
                pc_d       = RESET_PC_ALIGNED;
                id_valid_d = 1'b0;
            end
            FETCH: begin
                if (flush) begin
                    pc_d       = new_pc & ~32'd7;
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
                    misalign_d = |new_pc[2:0];
                end else if (branch_flag) begin
                    // No delay slot: the instruction in flight is squashed,
                    // even if decode is stalled.
                    pc_d       = branch_target & ~32'd7;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
                    misalign_d = |branch_target[2:0];
                end else if (!stall) begin
                    pc_d       = pc_q + 32'd8;
                    id_pc_d    = pc_q;
                    id_inst_d  = rom_inst;
                    id_valid_d = 1'b1;
`ifdef INST_FETCH_PERF_EN
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rom_ce_d = (state_d == FETCH);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            rom_ce_q   <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef INST_FETCH_PERF_EN
    // Fetch counter; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`endif

    assign rom_ce       = rom_ce_q;
    assign rom_addr     = pc_q;
    assign id_pc        = id_pc_q;
    assign id_inst      = id_inst_q;
    assign id_valid     = id_valid_q;
    assign misalign_err = misalign_q;

endmodule
